// File: rtl/vga_frame_reader.sv
`timescale 1ns/1ps
// vga_frame_reader: raster-scans the painter's frame buffer and produces
// 640x480@60 VGA timing from a 25 MHz pixel clock. Each frame-buffer pixel is
// replicated 2^SCALE_SHIFT times in x and y. A one-bit request/acknowledge
// handshake tells the painter when a vertical blank begins.
// Optional feature: define BOARD_GRID_OVERLAY_EN to draw a white lattice over
// the picture (every LATTICE_W-th column and LATTICE_H-th row of the buffer).
module vga_frame_reader #(
  parameter int SCR_WIDTH   = 160,
  parameter int SCR_HEIGHT  = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_BITS   = 15,
  parameter int COLOR_BITS  = 3,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
`ifdef BOARD_GRID_OVERLAY_EN
  ,
  parameter int LATTICE_W   = 10,
  parameter int LATTICE_H   = 7
`endif
) (
  input  logic                  Clck,
  input  logic                  Reset,
  output logic [ADDR_BITS-1:0]  address,
  input  logic [COLOR_BITS-1:0] mem_data,
  output logic [COLOR_BITS-1:0] vga_color,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  vga_blank,
  output logic                  out_cont_signal,
  input  logic                  next_out_cont_signal,
  output logic                  frame_overrun
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef enum logic {IDLE, REQ} state_t;

  logic [HW-1:0]        h_cnt;
  logic [VW-1:0]        v_cnt;
  logic                 h_wrap;
  logic                 v_wrap;
  logic                 vblank_start;
  state_t               state;

  logic                 active_p0, hs_p0, vs_p0;
  logic [31:0]          fx_p0, fy_p0, addr_full_p0;
  logic [ADDR_BITS-1:0] addr_p0;
  logic                 active_p1, hs_p1, vs_p1;
  logic                 active_p2, hs_p2, vs_p2;
  logic [COLOR_BITS-1:0] pix_p2;

  assign h_wrap       = (h_cnt == HW'(H_TOTAL - 1));
  assign v_wrap       = (v_cnt == VW'(V_TOTAL - 1));
  assign vblank_start = (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));

  // Raster counters: h_cnt over one line, v_cnt advances on each line wrap
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage 0: decode active area, syncs and the frame-buffer address
  always_comb begin
    active_p0    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hs_p0        = !((h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END)));
    vs_p0        = !((v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END)));
    fx_p0        = 32'(h_cnt) >> SCALE_SHIFT;
    fy_p0        = 32'(v_cnt) >> SCALE_SHIFT;
    addr_full_p0 = fx_p0 + fy_p0 * 32'(SCR_WIDTH);
    addr_p0      = (active_p0 && (fy_p0 < 32'(SCR_HEIGHT))) ? ADDR_BITS'(addr_full_p0) : '0;
  end

`ifdef BOARD_GRID_OVERLAY_EN
  localparam int XMW = $clog2(LATTICE_W + 1);
  localparam int YMW = $clog2(LATTICE_H + 1);
  localparam logic [HW-1:0] H_SUB = HW'((1 << SCALE_SHIFT) - 1);
  localparam logic [VW-1:0] V_SUB = VW'((1 << SCALE_SHIFT) - 1);

  logic [XMW-1:0] x_mod;
  logic [YMW-1:0] y_mod;
  logic           grid_p0, grid_p1, grid_p2;

  // Running fx % LATTICE_W and fy % LATTICE_H, stepped when a scaled pixel ends
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      x_mod <= '0;
      y_mod <= '0;
    end else if (h_wrap) begin
      x_mod <= '0;
      if (v_wrap)
        y_mod <= '0;
      else if ((v_cnt & V_SUB) == V_SUB)
        y_mod <= (y_mod == YMW'(LATTICE_H - 1)) ? '0 : y_mod + 1'b1;
    end else if ((h_cnt & H_SUB) == H_SUB) begin
      x_mod <= (x_mod == XMW'(LATTICE_W - 1)) ? '0 : x_mod + 1'b1;
    end
  end

  assign grid_p0 = (x_mod == '0) || (y_mod == '0);

  // Grid flag follows the same pipeline as the active flag
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      grid_p1 <= 1'b0;
      grid_p2 <= 1'b0;
    end else begin
      grid_p1 <= grid_p0;
      grid_p2 <= grid_p1;
    end
  end

  assign pix_p2 = grid_p2 ? '1 : mem_data;
`else
  assign pix_p2 = mem_data;
`endif

  // Stage 1: issue the memory address and capture the stage-0 flags
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      address   <= '0;
      active_p1 <= 1'b0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
    end else begin
      address   <= addr_p0;
      active_p1 <= active_p0;
      hs_p1     <= hs_p0;
      vs_p1     <= vs_p0;
    end
  end

  // Stage 2: flags wait one clock while the memory returns data
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      active_p2 <= 1'b0;
      hs_p2     <= 1'b1;
      vs_p2     <= 1'b1;
    end else begin
      active_p2 <= active_p1;
      hs_p2     <= hs_p1;
      vs_p2     <= vs_p1;
    end
  end

  // Stage 3: register colour, syncs and blank together so they stay aligned
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      vga_color <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_blank <= 1'b1;
    end else begin
      vga_color <= active_p2 ? pix_p2 : '0;
      vga_hsync <= hs_p2;
      vga_vsync <= vs_p2;
      vga_blank <= !active_p2;
    end
  end

  // Painter handshake: raise a request at vblank start, drop it on acknowledge;
  // an acknowledge coinciding with a new vblank re-arms the request
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      out_cont_signal <= 1'b0;
      frame_overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vblank_start) begin
            state           <= REQ;
            out_cont_signal <= 1'b1;
          end
        end
        REQ: begin
          if (next_out_cont_signal) begin
            if (!vblank_start) begin
              state           <= IDLE;
              out_cont_signal <= 1'b0;
            end
          end else if (vblank_start) begin
            frame_overrun <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          out_cont_signal <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
`timescale 1ns/1ps
// Bench for vga_frame_reader: one full-size instance for the 640x480 line
// timing and address checks, one shrunken-timing instance so that several
// frames (vsync, handshake, overrun) fit in a short run.
module tb_vga_frame_reader;

  localparam int S_HT    = 56;
  localparam int S_VT    = 19;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int S_VB_K  = 12 * S_HT;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  color;
    logic        hs;
    logic        vs;
    logic        blank;
  } vout_t;

  logic Clck = 1'b0;
  logic Reset;

  logic [14:0] addr_b, addr_s;
  logic [2:0]  mdata_b, mdata_s, color_b, color_s;
  logic        hs_b, vs_b, blank_b, req_b, ovr_b, ack_b;
  logic        hs_s, vs_s, blank_s, req_s, ovr_s, ack_s;

  logic [2:0]  mem [0:32767];
  longint      k;
  logic        exp_req, exp_ovr;
  logic        vb_s;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #20 Clck = ~Clck;

  vga_frame_reader u_big (
    .Clck(Clck), .Reset(Reset), .address(addr_b), .mem_data(mdata_b),
    .vga_color(color_b), .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_blank(blank_b),
    .out_cont_signal(req_b), .next_out_cont_signal(ack_b), .frame_overrun(ovr_b)
  );

  vga_frame_reader #(
    .SCR_WIDTH(10), .SCR_HEIGHT(3), .SCALE_SHIFT(2), .ADDR_BITS(15), .COLOR_BITS(3),
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .Clck(Clck), .Reset(Reset), .address(addr_s), .mem_data(mdata_s),
    .vga_color(color_s), .vga_hsync(hs_s), .vga_vsync(vs_s), .vga_blank(blank_s),
    .out_cont_signal(req_s), .next_out_cont_signal(ack_s), .frame_overrun(ovr_s)
  );

  // Synchronous-read frame buffers
  always @(posedge Clck) begin
    mdata_b <= mem[addr_b];
    mdata_s <= mem[addr_s];
  end

  // Edges since reset release
  always @(posedge Clck or posedge Reset) begin
    if (Reset) k <= 0;
    else       k <= k + 1;
  end

  // Expected painter request / overrun for the small instance
  always @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      exp_req <= 1'b0;
      exp_ovr <= 1'b0;
    end else begin
      vb_s = ((k % S_FRAME) == S_VB_K);
      if (vb_s) begin
        if (exp_req && !ack_s) exp_ovr <= 1'b1;
        exp_req <= 1'b1;
      end else if (ack_s) begin
        exp_req <= 1'b0;
      end
    end
  end

  // Expected address after edge kk and VGA outputs after edge kk
  function automatic vout_t model(input longint kk, input bit big);
    int ht, ha, hss, hse, vt, va, vss, vse, sw, h, v, fx, fy;
    vout_t o;
    if (big) begin
      ht = 800; ha = 640; hss = 656; hse = 752; vt = 525; va = 480; vss = 490; vse = 492; sw = 160;
    end else begin
      ht = S_HT; ha = 40; hss = 44; hse = 50; vt = S_VT; va = 12; vss = 14; vse = 16; sw = 10;
    end
    o = {15'd0, 3'd0, 3'b111};
    if (kk >= 1) begin
      h = int'((kk - 1) % ht);
      v = int'(((kk - 1) / ht) % vt);
      if (h < ha && v < va) o.addr = 15'((h / 4) + (v / 4) * sw);
    end
    if (kk >= 3) begin
      h = int'((kk - 3) % ht);
      v = int'(((kk - 3) / ht) % vt);
      o.hs    = !(h >= hss && h < hse);
      o.vs    = !(v >= vss && v < vse);
      o.blank = !(h < ha && v < va);
      if (!o.blank) begin
        fx = h / 4;
        fy = v / 4;
        o.color = mem[fx + fy * sw];
`ifdef BOARD_GRID_OVERLAY_EN
        if ((fx % 10) == 0 || (fy % 7) == 0) o.color = 3'b111;
`endif
      end
    end
    return o;
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    ack_b = 1'b0;
    ack_s = 1'b0;
    repeat (3) @(negedge Clck);
    n_checks++;
    if ({addr_b, color_b, hs_b, vs_b, blank_b} !== {15'd0, 3'd0, 3'b111}) begin
      n_fail++;
      $display("FAIL reset_big_outputs got %h want %h", {addr_b, color_b, hs_b, vs_b, blank_b}, {15'd0, 3'd0, 3'b111});
    end
    n_checks++;
    if ({addr_s, color_s, hs_s, vs_s, blank_s} !== {15'd0, 3'd0, 3'b111}) begin
      n_fail++;
      $display("FAIL reset_small_outputs got %h want %h", {addr_s, color_s, hs_s, vs_s, blank_s}, {15'd0, 3'd0, 3'b111});
    end
    n_checks++;
    if ({req_b, ovr_b, req_s, ovr_s} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_handshake got %b want 0000", {req_b, ovr_b, req_s, ovr_s});
    end
    Reset = 1'b0;
  endtask

  task automatic test_timing();
    vout_t  eb, es;
    longint hb_fall1 = -1, hb_rise1 = -1, hb_fall2 = -1;
    longint vs_fall1 = -1, vs_rise1 = -1, vs_fall2 = -1;
    logic   hb_prev = 1'b1, vs_prev = 1'b1;
    for (int i = 0; i < 7300; i++) begin
      @(negedge Clck);
      eb = model(k, 1'b1);
      es = model(k, 1'b0);
      n_checks++;
      if ({addr_b, color_b, hs_b, vs_b, blank_b} !== eb) begin
        n_fail++;
        $display("FAIL timing_big k=%0d got %h want %h", k, {addr_b, color_b, hs_b, vs_b, blank_b}, eb);
      end
      n_checks++;
      if ({addr_s, color_s, hs_s, vs_s, blank_s} !== es) begin
        n_fail++;
        $display("FAIL timing_small k=%0d got %h want %h", k, {addr_s, color_s, hs_s, vs_s, blank_s}, es);
      end
      n_checks++;
      if ({req_b, ovr_b, req_s, ovr_s} !== {2'b00, exp_req, exp_ovr}) begin
        n_fail++;
        $display("FAIL timing_handshake k=%0d got %b want %b", k, {req_b, ovr_b, req_s, ovr_s}, {2'b00, exp_req, exp_ovr});
      end
      if (hb_prev && !hs_b) begin
        if (hb_fall1 < 0) hb_fall1 = k;
        else if (hb_fall2 < 0) hb_fall2 = k;
      end
      if (!hb_prev && hs_b && hb_rise1 < 0) hb_rise1 = k;
      if (vs_prev && !vs_s) begin
        if (vs_fall1 < 0) vs_fall1 = k;
        else if (vs_fall2 < 0) vs_fall2 = k;
      end
      if (!vs_prev && vs_s && vs_rise1 < 0) vs_rise1 = k;
      hb_prev = hs_b;
      vs_prev = vs_s;
      if (k == 7206) begin
        n_checks++;
        if (addr_b !== 15'd321) begin
          n_fail++;
          $display("FAIL addr_5_9 got %0d want 321", addr_b);
        end
      end
      if (k == 7208) begin
        n_checks++;
        if (color_b !== 3'b101) begin
          n_fail++;
          $display("FAIL color_5_9 got %b want 101", color_b);
        end
      end
    end
    n_checks++;
    if (hb_fall1 != 659) begin n_fail++; $display("FAIL hsync_first_fall got %0d want 659", hb_fall1); end
    n_checks++;
    if (hb_rise1 - hb_fall1 != 96) begin n_fail++; $display("FAIL hsync_width got %0d want 96", hb_rise1 - hb_fall1); end
    n_checks++;
    if (hb_fall2 - hb_fall1 != 800) begin n_fail++; $display("FAIL line_period got %0d want 800", hb_fall2 - hb_fall1); end
    n_checks++;
    if (vs_fall1 != 14 * S_HT + 3) begin n_fail++; $display("FAIL vsync_first_fall got %0d want %0d", vs_fall1, 14 * S_HT + 3); end
    n_checks++;
    if (vs_rise1 - vs_fall1 != 2 * S_HT) begin n_fail++; $display("FAIL vsync_width got %0d want %0d", vs_rise1 - vs_fall1, 2 * S_HT); end
    n_checks++;
    if (vs_fall2 - vs_fall1 != S_FRAME) begin n_fail++; $display("FAIL frame_period got %0d want %0d", vs_fall2 - vs_fall1, S_FRAME); end
  endtask

  task automatic test_midline_reset();
    n_checks++;
    if ({req_s, ovr_s} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_overrun got %b want 11", {req_s, ovr_s});
    end
    @(posedge Clck);
    #7;
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({addr_b, color_b, hs_b, vs_b, blank_b, addr_s, color_s, hs_s, vs_s, blank_s} !==
        {15'd0, 3'd0, 3'b111, 15'd0, 3'd0, 3'b111}) begin
      n_fail++;
      $display("FAIL async_reset_outputs got %h/%h", {addr_b, color_b, hs_b, vs_b, blank_b}, {addr_s, color_s, hs_s, vs_s, blank_s});
    end
    n_checks++;
    if ({req_b, ovr_b, req_s, ovr_s} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_handshake got %b want 0000", {req_b, ovr_b, req_s, ovr_s});
    end
    repeat (2) @(negedge Clck);
    Reset = 1'b0;
  endtask

  task automatic test_handshake_ack();
    int cnt = 0;
    bit seen = 0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge Clck);
      n_checks++;
      if ({req_s, ovr_s} !== {exp_req, exp_ovr}) begin
        n_fail++;
        $display("FAIL ack_wait k=%0d got %b want %b", k, {req_s, ovr_s}, {exp_req, exp_ovr});
      end
      if (req_s === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ack_request_timeout got %b want 1", req_s);
    end
    n_checks++;
    if (k != S_VB_K + 1) begin
      n_fail++;
      $display("FAIL request_rise_edge got %0d want %0d", k, S_VB_K + 1);
    end
    cnt = 1;
    repeat (19) begin
      @(negedge Clck);
      if (req_s === 1'b1) cnt++;
    end
    ack_s = 1'b1;
    @(negedge Clck);
    ack_s = 1'b0;
    n_checks++;
    if (cnt != 20) begin n_fail++; $display("FAIL request_high_clocks got %0d want 20", cnt); end
    n_checks++;
    if (req_s !== 1'b0) begin n_fail++; $display("FAIL request_dropped got %b want 0", req_s); end
    n_checks++;
    if (ovr_s !== 1'b0) begin n_fail++; $display("FAIL ack_no_overrun got %b want 0", ovr_s); end
  endtask

  task automatic test_ack_collision();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge Clck);
      n_checks++;
      if ({req_s, ovr_s} !== {exp_req, exp_ovr}) begin
        n_fail++;
        $display("FAIL collision_wait k=%0d got %b want %b", k, {req_s, ovr_s}, {exp_req, exp_ovr});
      end
      if (req_s === 1'b1 && (k % S_FRAME) == S_VB_K) begin
        ack_s = 1'b1;
        done  = 1;
      end
    end
    @(negedge Clck);
    ack_s = 1'b0;
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL collision_timeout got 0 want 1"); end
    n_checks++;
    if (req_s !== 1'b1) begin n_fail++; $display("FAIL collision_rearm got %b want 1", req_s); end
    n_checks++;
    if (ovr_s !== 1'b0) begin n_fail++; $display("FAIL collision_no_overrun got %b want 0", ovr_s); end
    ack_s = 1'b1;
    @(negedge Clck);
    ack_s = 1'b0;
    n_checks++;
    if (req_s !== 1'b0) begin n_fail++; $display("FAIL collision_release got %b want 0", req_s); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 2 * S_FRAME + 20; i++) begin
      @(negedge Clck);
      n_checks++;
      if ({req_s, ovr_s} !== {exp_req, exp_ovr}) begin
        n_fail++;
        $display("FAIL overrun_trace k=%0d got %b want %b", k, {req_s, ovr_s}, {exp_req, exp_ovr});
      end
    end
    n_checks++;
    if ({req_s, ovr_s} !== 2'b11) begin
      n_fail++;
      $display("FAIL overrun_final got %b want 11", {req_s, ovr_s});
    end
  endtask

  task automatic test_random_ack();
    vout_t eb, es;
    int    pct = 5;
    for (int i = 0; i < 3 * S_FRAME; i++) begin
      @(negedge Clck);
      eb = model(k, 1'b1);
      es = model(k, 1'b0);
      n_checks++;
      if ({addr_b, color_b, hs_b, vs_b, blank_b} !== eb) begin
        n_fail++;
        $display("FAIL random_big k=%0d got %h want %h", k, {addr_b, color_b, hs_b, vs_b, blank_b}, eb);
      end
      n_checks++;
      if ({addr_s, color_s, hs_s, vs_s, blank_s} !== es) begin
        n_fail++;
        $display("FAIL random_small k=%0d got %h want %h", k, {addr_s, color_s, hs_s, vs_s, blank_s}, es);
      end
      n_checks++;
      if ({req_s, ovr_s} !== {exp_req, exp_ovr}) begin
        n_fail++;
        $display("FAIL random_handshake k=%0d got %b want %b", k, {req_s, ovr_s}, {exp_req, exp_ovr});
      end
      if ((k % S_FRAME) == 0) pct = int'($urandom_range(0, 2)) * 4;
      ack_s = ($urandom_range(0, 99) < pct);
    end
    ack_s = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom);
    mem[321] = 3'b101;
    test_reset();
    test_timing();
    test_midline_reset();
    test_handshake_ack();
    test_ack_collision();
    test_overrun();
    test_midline_reset();
    test_random_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
